// File: rtl/instr_fetch.sv
// instr_fetch: PC/fetch stage with branch-target LUT, IDLE/RUN/DONE sequencing and cycle counter; INSTR_FETCH_LINK_EN adds branch-and-link
module instr_fetch #(
  parameter int PC_W = 10,
  parameter int LUT_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [PC_W-1:0]              StartAddr,
  input  logic                         LutWrEn,
  input  logic [$clog2(LUT_DEPTH)-1:0] LutAddr,
  input  logic [PC_W-1:0]              LutData,
  input  logic                         Branch,
  input  logic                         CondFlag,
  input  logic [$clog2(LUT_DEPTH)-1:0] TargSel,
  input  logic                         Link,
  input  logic                         Ret,
  input  logic                         Ack,
  output logic [PC_W-1:0]              ProgCtr,
  output logic                         Running,
  output logic                         Done,
  output logic [CNT_W-1:0]             CycleCnt,
  output logic [PC_W-1:0]              LinkAddr
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [CNT_W-1:0] cnt_n;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic lut_we;
  logic take;
  logic ret;
  logic [PC_W-1:0] link_q;
  assign take = Branch && CondFlag;
  assign Running = state == RUN;
  assign Done = state == DONE;
  assign LinkAddr = link_q;
`ifdef INSTR_FETCH_LINK_EN
  assign ret = Ret;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      link_q <= '0;
    else if (state == RUN && !Ack && !Ret && take && Link)
      link_q <= ProgCtr + PC_W'(1);
  end
`else
  logic unused_link;
  assign unused_link = Link | Ret;
  assign ret = 1'b0;
  assign link_q = '0;
`endif
  always_comb begin
    state_n = state;
    pc_n = ProgCtr;
    cnt_n = CycleCnt;
    lut_we = 1'b0;
    if (state != RUN) begin
      lut_we = LutWrEn;
      if (Start) begin
        state_n = RUN;
        pc_n = StartAddr;
        cnt_n = '0;
      end
    end else begin
      cnt_n = &CycleCnt ? CycleCnt : CycleCnt + CNT_W'(1);
      // Ack freezes the PC; later rules only apply when no halt is pending
      if (Ack)
        state_n = DONE;
      else
        pc_n = ret ? link_q : take ? ProgCtr + lut[TargSel] : ProgCtr + PC_W'(1);
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ProgCtr <= '0;
      CycleCnt <= '0;
      lut <= '{default: '0};
    end else begin
      state <= state_n;
      ProgCtr <= pc_n;
      CycleCnt <= cnt_n;
      if (lut_we)
        lut[LutAddr] <= LutData;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table vectors, directed corner sequences and randomized run against a behavioural model
module tb_instr_fetch;
`ifdef INSTR_FETCH_LINK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start, LutWrEn, Branch, CondFlag, Link, Ret, Ack;
  logic [9:0] StartAddr, LutData;
  logic [1:0] LutAddr, TargSel;
  logic [9:0] ProgCtr, LinkAddr;
  logic Running, Done;
  logic [15:0] CycleCnt;
  int tests = 0;
  int fails = 0;
  int m_pc, m_cnt, m_link;
  bit m_run, m_done;
  int m_lut [4];

  instr_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .LutWrEn(LutWrEn), .LutAddr(LutAddr), .LutData(LutData),
    .Branch(Branch), .CondFlag(CondFlag), .TargSel(TargSel),
    .Link(Link), .Ret(Ret), .Ack(Ack),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .CycleCnt(CycleCnt), .LinkAddr(LinkAddr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit start;
    int saddr;
    bit br, cf;
    int ts;
    bit ack;
    int exp_pc;
    bit exp_run, exp_done;
  } vec_t;

  function automatic int wrap(int x);
    return ((x % 1024) + 1024) % 1024;
  endfunction

  function automatic int soff(int d);
    return d >= 512 ? d - 1024 : d;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_link = 0; m_run = 0; m_done = 0;
    for (int i = 0; i < 4; i++) m_lut[i] = 0;
  endtask

  task automatic model_step();
    if (!m_run) begin
      if (LutWrEn) m_lut[LutAddr] = soff(int'(LutData));
      if (Start) begin
        m_run = 1; m_done = 0; m_pc = int'(StartAddr); m_cnt = 0;
      end
    end else begin
      m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
      if (Ack) begin
        m_run = 0; m_done = 1;
      end else if (LK && Ret) m_pc = m_link;
      else if (Branch && CondFlag) begin
        if (LK && Link) m_link = wrap(m_pc + 1);
        m_pc = wrap(m_pc + m_lut[TargSel]);
      end else m_pc = wrap(m_pc + 1);
    end
  endtask

  task automatic check_all();
    chk("pc", int'(ProgCtr), m_pc);
    chk("running", int'(Running), int'(m_run));
    chk("done", int'(Done), int'(m_done));
    chk("cyclecnt", int'(CycleCnt), m_cnt);
    chk("linkaddr", int'(LinkAddr), m_link);
  endtask

  task automatic clr();
    Start = 0; StartAddr = 0; LutWrEn = 0; LutAddr = 0; LutData = 0;
    Branch = 0; CondFlag = 0; TargSel = 0; Link = 0; Ret = 0; Ack = 0;
  endtask

  task automatic tick(bit c);
    model_step();
    @(posedge Clk);
    #1;
    if (c) check_all();
  endtask

  task automatic lut_wr(int a, int d);
    clr();
    LutWrEn = 1; LutAddr = 2'(a); LutData = 10'(d);
    tick(1);
    clr();
  endtask

  task automatic go(int a);
    clr();
    Start = 1; StartAddr = 10'(a);
    tick(1);
    clr();
  endtask

  vec_t v [16];

  initial begin
    clr();
    model_reset();
    repeat (2) @(posedge Clk);
    #3 Reset = 0;
    #1;
    check_all();
    chk("reset_pc", int'(ProgCtr), 0);
    chk("reset_running", int'(Running), 0);
    lut_wr(0, 5);
    lut_wr(1, 10'h3FD);
    v[0]  = '{1, 'h010, 0, 0, 0, 0, 'h010, 1, 0};
    v[1]  = '{0, 0, 0, 0, 0, 0, 'h011, 1, 0};
    v[2]  = '{0, 0, 0, 0, 0, 0, 'h012, 1, 0};
    v[3]  = '{0, 0, 0, 0, 0, 0, 'h013, 1, 0};
    v[4]  = '{0, 0, 0, 0, 0, 1, 'h013, 0, 1};
    v[5]  = '{1, 'h020, 0, 0, 0, 0, 'h020, 1, 0};
    v[6]  = '{0, 0, 1, 1, 1, 0, 'h01D, 1, 0};
    v[7]  = '{0, 0, 0, 0, 0, 1, 'h01D, 0, 1};
    v[8]  = '{1, 'h020, 0, 0, 0, 0, 'h020, 1, 0};
    v[9]  = '{0, 0, 1, 0, 1, 0, 'h021, 1, 0};
    v[10] = '{0, 0, 0, 0, 0, 1, 'h021, 0, 1};
    v[11] = '{1, 'h3FF, 0, 0, 0, 0, 'h3FF, 1, 0};
    v[12] = '{0, 0, 0, 0, 0, 0, 'h000, 1, 0};
    v[13] = '{0, 0, 0, 0, 0, 0, 'h001, 1, 0};
    v[14] = '{0, 0, 1, 1, 1, 0, 'h3FE, 1, 0};
    v[15] = '{0, 0, 0, 0, 0, 1, 'h3FE, 0, 1};
    for (int i = 0; i < 16; i++) begin
      clr();
      Start = v[i].start; StartAddr = 10'(v[i].saddr);
      Branch = v[i].br; CondFlag = v[i].cf; TargSel = 2'(v[i].ts); Ack = v[i].ack;
      tick(1);
      chk($sformatf("vec%0d_pc", i), int'(ProgCtr), v[i].exp_pc);
      chk($sformatf("vec%0d_run", i), int'(Running), int'(v[i].exp_run));
      chk($sformatf("vec%0d_done", i), int'(Done), int'(v[i].exp_done));
    end
    // halt on the 7th RUN cycle, then hold in DONE and restart
    go('h200);
    chk("ack7_start_cnt", int'(CycleCnt), 0);
    repeat (6) tick(1);
    Ack = 1;
    tick(1);
    clr();
    chk("ack7_cnt", int'(CycleCnt), 7);
    chk("ack7_done", int'(Done), 1);
    chk("ack7_running", int'(Running), 0);
    repeat (10) tick(1);
    chk("ack7_frozen_pc", int'(ProgCtr), 'h206);
    chk("ack7_frozen_cnt", int'(CycleCnt), 7);
    go('h123);
    chk("restart_pc", int'(ProgCtr), 'h123);
    chk("restart_done", int'(Done), 0);
    chk("restart_cnt", int'(CycleCnt), 0);
    repeat (65540) tick(0);
    check_all();
    chk("cnt_saturated", int'(CycleCnt), 'hFFFF);
    // branch-and-link and return
    Reset = 1;
    model_reset();
    #2 Reset = 0;
    clr();
    @(negedge Clk);
    lut_wr(0, 5);
    go('h040);
    Branch = 1; CondFlag = 1; TargSel = 0; Link = 1;
    tick(1);
    clr();
    chk("link_pc", int'(ProgCtr), 'h045);
    chk("link_addr", int'(LinkAddr), LK ? 'h041 : 0);
    Ret = 1;
    tick(1);
    clr();
    chk("ret_pc", int'(ProgCtr), LK ? 'h041 : 'h046);
    Ack = 1; Ret = 1;
    tick(1);
    clr();
    chk("ack_over_ret_done", int'(Done), 1);
    // asynchronous reset in the middle of RUN
    go('h055);
    chk("pre_reset_pc", int'(ProgCtr), 'h055);
    #2 Reset = 1;
    model_reset();
    #1;
    chk("async_pc", int'(ProgCtr), 0);
    chk("async_running", int'(Running), 0);
    chk("async_cnt", int'(CycleCnt), 0);
    chk("async_link", int'(LinkAddr), 0);
    #1 Reset = 0;
    go('h100);
    Branch = 1; CondFlag = 1; TargSel = 0;
    tick(1);
    clr();
    chk("lut_cleared_pc", int'(ProgCtr), 'h100);
    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      StartAddr = 10'($urandom);
      LutWrEn = ($urandom_range(0, 3) == 0);
      LutAddr = 2'($urandom);
      LutData = 10'($urandom);
      Branch = 1'($urandom);
      CondFlag = 1'($urandom);
      TargSel = 2'($urandom);
      Link = 1'($urandom);
      Ret = ($urandom_range(0, 7) == 0);
      Ack = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-counter / fetch stage directly upstream of the control decoder.
- Drives ProgCtr into instruction ROM; the ROM output feeds the decoder, whose Branch/Link/Ack outputs return here the same cycle.
- Owns the 4-entry relative branch-target LUT, run/done sequencing with the test bench, and a cycle counter.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- LUT_DEPTH, 4, target LUT entries; index width = $clog2(LUT_DEPTH).
- CNT_W, 16, cycle counter width.

Ports:
- Clk  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  bench request to begin/restart program.
- StartAddr  in  PC_W  first PC loaded on Start.
- LutWrEn  in  1  write target LUT (IDLE/DONE only).
- LutAddr  in  $clog2(LUT_DEPTH)  LUT write index.
- LutData  in  PC_W  signed two's-complement PC offset.
- Branch  in  1  decoder: current instruction is a branch.
- CondFlag  in  1  ALU condition flag; branch taken iff Branch && CondFlag.
- TargSel  in  $clog2(LUT_DEPTH)  LUT index, from instruction bits [3:2].
- Link  in  1  decoder: branch-and-link.
- Ret  in  1  return to link address.
- Ack  in  1  decoder: halt instruction (9'b111111111).
- ProgCtr  out  PC_W  instruction ROM address.
- Running  out  1  high in RUN.
- Done  out  1  program finished.
- CycleCnt  out  CNT_W  RUN cycles executed, saturating.
- LinkAddr  out  PC_W  saved return address.

Behaviour:
- Reset, asynchronous: state=IDLE; ProgCtr=0; Done=0; Running=0; CycleCnt=0; LinkAddr=0; all LUT entries=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start -> RUN next edge; ProgCtr<=StartAddr; CycleCnt<=0; Done stays 0.
  - LutWrEn writes LUT[LutAddr]<=LutData.
- RUN: per edge, first matching rule wins:
  - (1) Ack -> DONE; ProgCtr held; Done<=1.
  - (2) Ret -> ProgCtr<=LinkAddr.
  - (3) Branch&&CondFlag -> ProgCtr<=ProgCtr+LUT[TargSel], mod 2^PC_W.
  - (4) otherwise -> ProgCtr<=ProgCtr+1, wraps from 2^PC_W-1 to 0.
  - Branch without CondFlag -> rule 4.
  - LutWrEn ignored in RUN.
  - Start ignored in RUN.
- CycleCnt: +1 each RUN edge, including the Ack edge; holds at 2^CNT_W-1; holds in IDLE/DONE.
- DONE:
  - Done=1, Running=0; ProgCtr and CycleCnt held.
  - LutWrEn permitted.
  - Start -> RUN at StartAddr; Done<=0; CycleCnt<=0.
- Running = (state==RUN), registered with state; a new PC is visible one edge after the decision.
- LUT offset 0 on taken branch: ProgCtr holds; legal self-loop.
- Reset mid-RUN: immediate return to reset values; the LUT is cleared.
- Start and LutWrEn together in IDLE/DONE: both take effect.

Optional Feature:
- Macro: INSTR_FETCH_LINK_EN.
- Defined:
  - Taken branch with Link=1 also loads LinkAddr<=ProgCtr+1, wrapping.
  - Ret performs rule 2.
  - Ack+Ret in the same cycle -> Ack wins.
- Undefined:
  - Link and Ret ignored; Ret falls through to rules 3/4.
  - LinkAddr constant 0.
  - No link register synthesised.

Test Plan:
- Reset; LUT write {0:+5, 1:-3}; Start with StartAddr=0x010; four plain cycles -> ProgCtr 0x010,0x011,0x012,0x013; Running=1.
- At PC=0x020, Branch=1, CondFlag=1, TargSel=1 -> next ProgCtr=0x01D; same with CondFlag=0 -> 0x021.
- StartAddr=0x3FF (PC_W=10), no branch -> ProgCtr 0x3FF then 0x000; taken branch offset -3 at 0x001 -> 0x3FE.
- Ack at 7th RUN cycle -> Done=1, Running=0, CycleCnt=7, ProgCtr frozen 10 cycles; Start -> Done=0, ProgCtr=StartAddr, CycleCnt=0.
- LINK_EN defined:
  - Taken branch+Link at 0x040 with offset +5 -> ProgCtr=0x045, LinkAddr=0x041.
  - Ret -> ProgCtr=0x041.
- LINK_EN undefined: same stimulus -> LinkAddr=0 and Ret gives 0x046.
- Assert Reset mid-RUN at PC=0x055 -> outputs zero asynchronously, state IDLE, LUT reads 0 (taken branch after restart adds 0).
